// File: rtl/alu_req_sequencer_if.sv
// Requester, response and ALU-side signal bundle for alu_req_sequencer.
// slave is the sequencer's view; master is the view of the requesters, response consumer and ALU.
interface alu_req_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 4,
  parameter int N_REQ      = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ*DATA_WIDTH-1:0] req_opa;
  logic [N_REQ*DATA_WIDTH-1:0] req_opb;
  logic [N_REQ*CMD_WIDTH-1:0]  req_cmd;
  logic [N_REQ-1:0]            req_mode;
  logic [N_REQ-1:0]            req_cin;

  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [ID_W-1:0]             rsp_id;
  logic [DATA_WIDTH:0]         rsp_res;
  logic [5:0]                  rsp_flags;
  logic                        busy;

  logic [DATA_WIDTH-1:0]       alu_opa;
  logic [DATA_WIDTH-1:0]       alu_opb;
  logic [CMD_WIDTH-1:0]        alu_cmd;
  logic                        alu_mode;
  logic                        alu_cin;
  logic [1:0]                  alu_inp_valid;
  logic                        alu_ce;
  logic [DATA_WIDTH:0]         alu_res;
  logic                        alu_oflow;
  logic                        alu_cout;
  logic                        alu_g;
  logic                        alu_l;
  logic                        alu_e;
  logic                        alu_err;

  modport slave (
    input  req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin,
    output req_ready,
    output rsp_valid, rsp_id, rsp_res, rsp_flags, busy,
    input  rsp_ready,
    output alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_inp_valid, alu_ce,
    input  alu_res, alu_oflow, alu_cout, alu_g, alu_l, alu_e, alu_err
  );

  modport master (
    output req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_res, rsp_flags, busy,
    output rsp_ready,
    input  alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_inp_valid, alu_ce,
    output alu_res, alu_oflow, alu_cout, alu_g, alu_l, alu_e, alu_err
  );
endinterface

// File: rtl/alu_req_sequencer.sv
// Shares one ALU between N_REQ requesters: arbitrate, issue, wait latency, return result with ID.
// Define ALU_SEQ_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module alu_req_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 4,
  parameter int N_REQ      = 4,
  parameter int ALU_LAT    = 1,
  parameter int MUL_LAT    = 2
) (
  input  logic               clk,
  input  logic               RST_N,
  alu_req_sequencer_if.slave bus
);
  localparam int ID_W    = $clog2(N_REQ);
  localparam int MAX_LAT = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t state_q, state_nxt;

  logic [ID_W-1:0]       grant_id;
  logic [N_REQ-1:0]      grant;
  logic                  any_req;
  logic                  accept;

  logic [DATA_WIDTH-1:0] opa_p0, opa_nxt;
  logic [DATA_WIDTH-1:0] opb_p0, opb_nxt;
  logic [CMD_WIDTH-1:0]  cmd_p0, cmd_nxt;
  logic                  mode_p0, mode_nxt;
  logic                  cin_p0, cin_nxt;
  logic [1:0]            vld_p0, vld_p0_nxt;
  logic                  ce_p0, ce_nxt;
  logic [ID_W-1:0]       id_p0, id_p0_nxt;
  logic [CNT_W-1:0]      cnt_p0, cnt_nxt;

  logic                  vld_p1, vld_p1_nxt;
  logic [ID_W-1:0]       id_p1, id_p1_nxt;
  logic [DATA_WIDTH:0]   res_p1, res_nxt;
  logic [5:0]            flags_p1, flags_nxt;
  logic                  busy_q, busy_nxt;

  // Multiply commands take the longer ALU path.
  function automatic logic [CNT_W-1:0] op_latency(input logic mode,
                                                  input logic [CMD_WIDTH-1:0] cmd);
    if (mode && (cmd == CMD_WIDTH'(9) || cmd == CMD_WIDTH'(10)))
      return CNT_W'(MUL_LAT);
    return CNT_W'(ALU_LAT);
  endfunction

  assign any_req = |bus.req_valid;

`ifdef ALU_SEQ_FIXED_PRIO_EN
  always_comb begin
    grant_id = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (bus.req_valid[i]) grant_id = ID_W'(i);
  end
`else
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] cand;

  // Walk the search order backwards so the earliest candidate after ptr_q wins.
  always_comb begin
    grant_id = '0;
    cand     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ID_W'((int'(ptr_q) + 1 + i) % N_REQ);
      if (bus.req_valid[cand]) grant_id = cand;
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N)      ptr_q <= ID_W'(N_REQ - 1);
    else if (accept) ptr_q <= grant_id;
  end
`endif

  assign grant         = any_req ? (N_REQ'(1) << grant_id) : '0;
  assign bus.req_ready = (state_q == S_IDLE) ? grant : '0;
  assign accept        = (state_q == S_IDLE) && any_req;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (cnt_p0 == CNT_W'(1)) state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    opa_nxt    = opa_p0;
    opb_nxt    = opb_p0;
    cmd_nxt    = cmd_p0;
    mode_nxt   = mode_p0;
    cin_nxt    = cin_p0;
    vld_p0_nxt = vld_p0;
    ce_nxt     = ce_p0;
    id_p0_nxt  = id_p0;
    cnt_nxt    = cnt_p0;
    vld_p1_nxt = vld_p1;
    id_p1_nxt  = id_p1;
    res_nxt    = res_p1;
    flags_nxt  = flags_p1;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          opa_nxt    = bus.req_opa[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
          opb_nxt    = bus.req_opb[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
          cmd_nxt    = bus.req_cmd[int'(grant_id)*CMD_WIDTH +: CMD_WIDTH];
          mode_nxt   = bus.req_mode[grant_id];
          cin_nxt    = bus.req_cin[grant_id];
          id_p0_nxt  = grant_id;
          vld_p0_nxt = 2'b11;
          ce_nxt     = 1'b1;
        end
      end
      S_ISSUE: begin
        vld_p0_nxt = 2'b00;
        cnt_nxt    = op_latency(mode_p0, cmd_p0);
      end
      S_WAIT: begin
        cnt_nxt = cnt_p0 - CNT_W'(1);
        if (cnt_p0 == CNT_W'(1)) begin
          ce_nxt     = 1'b0;
          vld_p1_nxt = 1'b1;
          id_p1_nxt  = id_p0;
          res_nxt    = bus.alu_res;
          flags_nxt  = {bus.alu_err, bus.alu_oflow, bus.alu_cout,
                        bus.alu_g, bus.alu_l, bus.alu_e};
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) vld_p1_nxt = 1'b0;
      end
      default: ;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  // issue stage: ALU input bus, latched requester ID and latency counter
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      opa_p0  <= '0;
      opb_p0  <= '0;
      cmd_p0  <= '0;
      mode_p0 <= 1'b0;
      cin_p0  <= 1'b0;
      vld_p0  <= 2'b00;
      ce_p0   <= 1'b0;
      id_p0   <= '0;
      cnt_p0  <= '0;
    end else begin
      opa_p0  <= opa_nxt;
      opb_p0  <= opb_nxt;
      cmd_p0  <= cmd_nxt;
      mode_p0 <= mode_nxt;
      cin_p0  <= cin_nxt;
      vld_p0  <= vld_p0_nxt;
      ce_p0   <= ce_nxt;
      id_p0   <= id_p0_nxt;
      cnt_p0  <= cnt_nxt;
    end
  end

  // response stage: captured ALU result held until the consumer takes it
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      vld_p1   <= 1'b0;
      id_p1    <= '0;
      res_p1   <= '0;
      flags_p1 <= '0;
      busy_q   <= 1'b0;
    end else begin
      vld_p1   <= vld_p1_nxt;
      id_p1    <= id_p1_nxt;
      res_p1   <= res_nxt;
      flags_p1 <= flags_nxt;
      busy_q   <= busy_nxt;
    end
  end

  assign bus.alu_opa       = opa_p0;
  assign bus.alu_opb       = opb_p0;
  assign bus.alu_cmd       = cmd_p0;
  assign bus.alu_mode      = mode_p0;
  assign bus.alu_cin       = cin_p0;
  assign bus.alu_inp_valid = vld_p0;
  assign bus.alu_ce        = ce_p0;
  assign bus.rsp_valid     = vld_p1;
  assign bus.rsp_id        = id_p1;
  assign bus.rsp_res       = res_p1;
  assign bus.rsp_flags     = flags_p1;
  assign bus.busy          = busy_q;
endmodule

// File: tb/tb_alu_req_sequencer.sv
// Directed bench for alu_req_sequencer with a small stand-in ALU that only
// presents its result during the cycle the sequencer is expected to capture it.
module tb_alu_req_sequencer;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic RST_N;
  int   checks = 0;
  int   errors = 0;

  alu_req_sequencer_if #(.DATA_WIDTH(DW), .CMD_WIDTH(CW), .N_REQ(NR)) bus ();

  alu_req_sequencer #(
    .DATA_WIDTH(DW), .CMD_WIDTH(CW), .N_REQ(NR), .ALU_LAT(1), .MUL_LAT(2)
  ) dut (
    .clk  (clk),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: {flags, res}; garbage outside its output-valid cycle.
  function automatic logic [14:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] c, input logic m);
    logic [8:0] r;
    logic       err;
    r   = '0;
    err = 1'b0;
    if (m) begin
      case (c)
        4'd0:        r = {1'b0, a} + {1'b0, b};
        4'd9, 4'd10: r = {1'b0, a} * {1'b0, b};
        default:     r = '0;
      endcase
    end else begin
      case (c)
        4'd12: begin
          err = |b[7:4];
          r   = err ? 9'h000 : {1'b0, a << b[2:0]};
        end
        default: r = {1'b0, a ^ b};
      endcase
    end
    return {err, 1'b0, m & r[8], a > b, a < b, a == b, r};
  endfunction

  logic [8:0] m_res;
  logic [5:0] m_flags;
  int         m_cnt;

  always @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      m_cnt   <= 0;
      m_res   <= '0;
      m_flags <= '0;
    end else if (bus.alu_ce && bus.alu_inp_valid == 2'b11) begin
      {m_flags, m_res} <= alu_fn(bus.alu_opa, bus.alu_opb, bus.alu_cmd, bus.alu_mode);
      m_cnt <= (bus.alu_mode && (bus.alu_cmd == 4'd9 || bus.alu_cmd == 4'd10)) ? 2 : 1;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign bus.alu_res = (m_cnt == 1) ? m_res : 9'h1AA;
  assign {bus.alu_err, bus.alu_oflow, bus.alu_cout, bus.alu_g, bus.alu_l, bus.alu_e} =
         (m_cnt == 1) ? m_flags : 6'b010101;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] c, input logic m);
    bus.req_opa[p*DW +: DW] = a;
    bus.req_opb[p*DW +: DW] = b;
    bus.req_cmd[p*CW +: CW] = c;
    bus.req_mode[p[1:0]]    = m;
    bus.req_cin[p[1:0]]     = 1'b0;
    bus.req_valid[p[1:0]]   = 1'b1;
  endtask

  task automatic clr_req(input int p);
    bus.req_valid[p[1:0]] = 1'b0;
  endtask

  int         exp_id  [5];
  logic [8:0] exp_res [5];
  int         n;

  initial begin
`ifdef ALU_SEQ_FIXED_PRIO_EN
    exp_id  = '{0, 0, 0, 0, 0};
    exp_res = '{9'h001, 9'h001, 9'h001, 9'h001, 9'h001};
`else
    exp_id  = '{0, 1, 2, 3, 0};
    exp_res = '{9'h001, 9'h011, 9'h021, 9'h031, 9'h001};
`endif
    RST_N         = 1'b0;
    bus.req_valid = '0;
    bus.req_opa   = '0;
    bus.req_opb   = '0;
    bus.req_cmd   = '0;
    bus.req_mode  = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) tick();

    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_id",    32'(bus.rsp_id), 0);
    chk("rst_rsp_res",   32'(bus.rsp_res), 0);
    chk("rst_rsp_flags", 32'(bus.rsp_flags), 0);
    chk("rst_busy",      32'(bus.busy), 0);
    chk("rst_alu_opa",   32'(bus.alu_opa), 0);
    chk("rst_alu_iv",    32'(bus.alu_inp_valid), 0);
    chk("rst_alu_ce",    32'(bus.alu_ce), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);

    RST_N = 1'b1;
    tick();

    // Single ADD from port 0
    set_req(0, 8'h0F, 8'h01, 4'd0, 1'b1);
    #1;
    chk("t1_req_ready", 32'(bus.req_ready), 'b0001);
    tick();
    clr_req(0);
    chk("t1_issue_iv",    32'(bus.alu_inp_valid), 'b11);
    chk("t1_issue_ce",    32'(bus.alu_ce), 1);
    chk("t1_issue_opa",   32'(bus.alu_opa), 'h0F);
    chk("t1_issue_opb",   32'(bus.alu_opb), 'h01);
    chk("t1_issue_busy",  32'(bus.busy), 1);
    chk("t1_issue_ready", 32'(bus.req_ready), 0);
    tick();
    chk("t1_wait_iv",    32'(bus.alu_inp_valid), 0);
    chk("t1_wait_ce",    32'(bus.alu_ce), 1);
    chk("t1_wait_rsp",   32'(bus.rsp_valid), 0);
    chk("t1_wait_opa",   32'(bus.alu_opa), 'h0F);
    tick();
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("t1_rsp_res",   32'(bus.rsp_res), 'h010);
    chk("t1_rsp_id",    32'(bus.rsp_id), 0);
    chk("t1_rsp_flags", 32'(bus.rsp_flags), 'b000100);
    chk("t1_rsp_ce",    32'(bus.alu_ce), 0);
    tick();
    chk("t1_idle_rsp",  32'(bus.rsp_valid), 0);
    chk("t1_idle_busy", 32'(bus.busy), 0);

    // Multiply from port 2: two WAIT cycles
    set_req(2, 8'h03, 8'h05, 4'd9, 1'b1);
    #1;
    chk("t2_req_ready", 32'(bus.req_ready), 'b0100);
    tick();
    clr_req(2);
    chk("t2_issue_iv",  32'(bus.alu_inp_valid), 'b11);
    chk("t2_issue_cmd", 32'(bus.alu_cmd), 9);
    tick();
    chk("t2_wait1_rsp", 32'(bus.rsp_valid), 0);
    chk("t2_wait1_iv",  32'(bus.alu_inp_valid), 0);
    tick();
    chk("t2_wait2_rsp", 32'(bus.rsp_valid), 0);
    chk("t2_wait2_ce",  32'(bus.alu_ce), 1);
    tick();
    chk("t2_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("t2_rsp_res",   32'(bus.rsp_res), 'h00F);
    chk("t2_rsp_id",    32'(bus.rsp_id), 2);
    chk("t2_rsp_flags", 32'(bus.rsp_flags), 'b000010);
    tick();
    chk("t2_idle_rsp",  32'(bus.rsp_valid), 0);

    // Error pass-through on port 1, then hold the response off for 10 cycles
    bus.rsp_ready = 1'b0;
    set_req(1, 8'h81, 8'h10, 4'd12, 1'b0);
    #1;
    chk("t6_req_ready", 32'(bus.req_ready), 'b0010);
    tick();
    clr_req(1);
    tick();
    tick();
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("t6_err_bit",   32'(bus.rsp_flags[5]), 1);
    chk("t6_rsp_flags", 32'(bus.rsp_flags), 'b100100);
    chk("t6_rsp_res",   32'(bus.rsp_res), 0);
    chk("t6_rsp_id",    32'(bus.rsp_id), 1);
    set_req(3, 8'hA5, 8'h02, 4'd10, 1'b1);
    #1;
    for (int k = 0; k < 10; k++) begin
      chk("t4_hold_valid", 32'(bus.rsp_valid), 1);
      chk("t4_hold_res",   32'(bus.rsp_res), 0);
      chk("t4_hold_flags", 32'(bus.rsp_flags), 'b100100);
      chk("t4_hold_id",    32'(bus.rsp_id), 1);
      chk("t4_no_ready",   32'(bus.req_ready), 0);
      chk("t4_ce_low",     32'(bus.alu_ce), 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("t4_idle_rsp",   32'(bus.rsp_valid), 0);
    chk("t4_idle_ready", 32'(bus.req_ready), 'b1000);
    tick();
    clr_req(3);
    chk("t4_issue_opa",  32'(bus.alu_opa), 'hA5);
    chk("t4_issue_cmd",  32'(bus.alu_cmd), 10);
    chk("t4_issue_iv",   32'(bus.alu_inp_valid), 'b11);
    tick();
    chk("t5_wait_ce",    32'(bus.alu_ce), 1);
    chk("t5_wait_busy",  32'(bus.busy), 1);

    // Reset in the middle of WAIT, away from any clock edge
    #2;
    RST_N = 1'b0;
    #1;
    chk("t5_async_ce",   32'(bus.alu_ce), 0);
    chk("t5_async_iv",   32'(bus.alu_inp_valid), 0);
    chk("t5_async_opa",  32'(bus.alu_opa), 0);
    chk("t5_async_opb",  32'(bus.alu_opb), 0);
    chk("t5_async_cmd",  32'(bus.alu_cmd), 0);
    chk("t5_async_mode", 32'(bus.alu_mode), 0);
    chk("t5_async_busy", 32'(bus.busy), 0);
    chk("t5_async_rsp",  32'(bus.rsp_valid), 0);
    repeat (2) tick();
    RST_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_no_stale_rsp", 32'(bus.rsp_valid), 0);
      chk("t5_post_busy",    32'(bus.busy), 0);
    end

    // All four ports requesting continuously
    for (int p = 0; p < NR; p++)
      set_req(p, 8'(p * 16), 8'h01, 4'd0, 1'b1);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t3_grant", 32'(bus.req_ready), 32'(1) << exp_id[k]);
      tick();
      n = 0;
      while (!bus.rsp_valid && n < 10) begin
        tick();
        n++;
      end
      chk("t3_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("t3_latency",   32'(n), 2);
      chk("t3_rsp_id",    32'(bus.rsp_id), 32'(exp_id[k]));
      chk("t3_rsp_res",   32'(bus.rsp_res), 32'(exp_res[k]));
      tick();
    end
    bus.req_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
